tcon_timing_gen: RTL

Parametrised display-timing generator for the TCON datapath. It generates HS, VS and DE with the layout sync → back porch → active → front porch on both axes. Configuration is double-buffered and changes only at frame boundaries. It adds per-signal polarity, a DE-only mode, a line-match interrupt, frame start/count and a configuration-error state. It drives the TCON pipeline directly, and its h/v counters feed downstream pixel-address logic.

---
 rtl/tcon_pkg.sv | 32 +++
 rtl/tcon_axis_cnt.sv | 61 ++++++
 rtl/tcon_timing_gen.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tcon_pkg.sv
// Shared types and constants for the TCON display-timing generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tcon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_ERR  = 2'd3
    } tcon_state_e;

    localparam int TCON_HCNT_BW = 12;
    localparam int TCON_VCNT_BW = 12;
    localparam int TCON_HSPM_BW = 8;
    localparam int TCON_VSPM_BW = 8;
    localparam int TCON_FCNT_BW = 8;

    // Per-frame mode bits held in the shadow set
    typedef struct packed {
        logic hs_pol;
        logic vs_pol;
        logic de_pol;
        logic de_only;
    } tcon_mode_t;

    // Level a timing output sits at when its raw signal is deasserted
    function automatic logic inactive_lvl(input logic pol);
        return ~pol;
    endfunction

endpackage

// File: rtl/tcon_axis_cnt.sv
// One timing axis: position counter, wrap compare, sync and active window decode.
// Latency: counter updates on the clock edge; decodes are combinational from the counter.
// Backpressure: none; advances whenever step_i is high, clr_i has priority.
module tcon_axis_cnt
    import tcon_pkg::*;
#(
    parameter int CNT_BW = TCON_HCNT_BW,
    parameter int PM_BW  = TCON_HSPM_BW
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr_i,
    input  logic              step_i,
    input  logic [PM_BW-1:0]  pw_i,
    input  logic [PM_BW-1:0]  bp_i,
    input  logic [CNT_BW-1:0] at_i,
    input  logic [PM_BW-1:0]  fp_i,
    output logic [CNT_BW-1:0] cnt_o,
    output logic              wrap_o,
    output logic              sync_o,
    output logic              act_o
);
    // One extra bit so a total of exactly 2^CNT_BW is representable
    localparam int TW = CNT_BW + 1;

    logic [CNT_BW-1:0] cnt_q, cnt_d;
    logic [TW-1:0]     total, act_start, act_end, cnt_ext;

    // Window boundaries derived from the shadowed geometry
    always_comb begin
        total     = TW'(pw_i) + TW'(bp_i) + TW'(at_i) + TW'(fp_i);
        act_start = TW'(pw_i) + TW'(bp_i);
        act_end   = act_start + TW'(at_i);
        cnt_ext   = TW'(cnt_q);
    end

    assign wrap_o = (cnt_ext == (total - TW'(1)));
    assign sync_o = (cnt_ext < TW'(pw_i));
    assign act_o  = (cnt_ext >= act_start) && (cnt_ext < act_end);
    assign cnt_o  = cnt_q;

    // Next count: clear wins, otherwise step and wrap at total-1
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (step_i) begin
            cnt_d = wrap_o ? '0 : cnt_q + CNT_BW'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tcon_timing_gen.sv
// Display timing generator: HS/VS/DE with polarity, DE-only mode, line IRQ, frame count, shadowed config.
// Latency: enable to first frame_start is 3 cycles; timing outputs lag h_cnt/v_cnt by 1 cycle.
// Backpressure: none; free-running while enabled, enable low returns to idle on the next cycle.
module tcon_timing_gen
    import tcon_pkg::*;
#(
    parameter int HCNT_BW = TCON_HCNT_BW,
    parameter int VCNT_BW = TCON_VCNT_BW,
    parameter int HSPM_BW = TCON_HSPM_BW,
    parameter int VSPM_BW = TCON_VSPM_BW,
    parameter int FCNT_BW = TCON_FCNT_BW
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               enable,
    input  logic [HSPM_BW-1:0] reg_hspw,
    input  logic [HSPM_BW-1:0] reg_hsbp,
    input  logic [HSPM_BW-1:0] reg_hsfp,
    input  logic [HCNT_BW-1:0] reg_hsat,
    input  logic [VSPM_BW-1:0] reg_vspw,
    input  logic [VSPM_BW-1:0] reg_vsbp,
    input  logic [VSPM_BW-1:0] reg_vsfp,
    input  logic [VCNT_BW-1:0] reg_vsat,
    input  logic               reg_hs_pol,
    input  logic               reg_vs_pol,
    input  logic               reg_de_pol,
    input  logic               reg_de_only,
    input  logic [VCNT_BW-1:0] reg_line_irq,
    input  logic               reg_upd,
    output logic [HCNT_BW-1:0] h_cnt,
    output logic [VCNT_BW-1:0] v_cnt,
    output logic               hs_out,
    output logic               vs_out,
    output logic               de_out,
    output logic               frame_start,
    output logic               line_irq,
    output logic [FCNT_BW-1:0] frame_cnt,
    output logic               upd_done,
    output logic               cfg_err
);
    localparam int HTW = HCNT_BW + 1;
    localparam int VTW = VCNT_BW + 1;
    localparam logic [HTW-1:0] HT_MAX = {1'b1, {HCNT_BW{1'b0}}};
    localparam logic [VTW-1:0] VT_MAX = {1'b1, {VCNT_BW{1'b0}}};

    tcon_state_e state_q, state_d;

    // Shadow set, loaded on LOAD and on a pending frame-end reload
    logic [HSPM_BW-1:0] hspw_q, hsbp_q, hsfp_q;
    logic [HCNT_BW-1:0] hsat_q;
    logic [VSPM_BW-1:0] vspw_q, vsbp_q, vsfp_q;
    logic [VCNT_BW-1:0] vsat_q, line_irq_cfg_q;
    tcon_mode_t         mode_q, mode_in;

    logic               upd_pending_q, upd_pending_d;
    logic [FCNT_BW-1:0] frame_cnt_q;
    logic               hs_q, vs_q, de_q, frame_start_q, line_irq_q, upd_done_q, cfg_err_q;

    logic               run, cnt_clr, v_step, frame_end, reload, shd_load, cfg_ok;
    logic               hs_raw, vs_raw, de_raw;
    logic [HTW-1:0]     ht_chk;
    logic [VTW-1:0]     vt_chk;
    logic [HCNT_BW-1:0] h_cnt_w;
    logic [VCNT_BW-1:0] v_cnt_w;
    logic               h_wrap, h_sync, h_act, v_wrap, v_sync, v_act;

    assign mode_in = '{hs_pol: reg_hs_pol, vs_pol: reg_vs_pol,
                       de_pol: reg_de_pol, de_only: reg_de_only};

    // Validity of the candidate configuration presented on reg_*
    always_comb begin
        ht_chk = HTW'(reg_hspw) + HTW'(reg_hsbp) + HTW'(reg_hsat) + HTW'(reg_hsfp);
        vt_chk = VTW'(reg_vspw) + VTW'(reg_vsbp) + VTW'(reg_vsat) + VTW'(reg_vsfp);
        cfg_ok = (reg_hsat != '0) && (reg_vsat != '0)
              && (ht_chk <= HT_MAX) && (vt_chk <= VT_MAX)
              && (ht_chk >= HTW'(2)) && (vt_chk >= VTW'(2));
    end

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; enable low always returns to IDLE
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_LOAD;
                ST_LOAD: state_d = cfg_ok ? ST_RUN : ST_ERR;
                ST_RUN:  if (reload && !cfg_ok) state_d = ST_ERR;
                ST_ERR:  state_d = ST_ERR;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: counting only while running and still enabled
    always_comb begin
        run       = (state_q == ST_RUN) && enable;
        cnt_clr   = !run;
        v_step    = run && h_wrap;
        frame_end = run && h_wrap && v_wrap;
        reload    = frame_end && upd_pending_q;
        shd_load  = ((state_q == ST_LOAD) && enable) || reload;
    end

    tcon_axis_cnt #(.CNT_BW(HCNT_BW), .PM_BW(HSPM_BW)) u_h_axis (
        .clk    (clk),
        .rstn   (rstn),
        .clr_i  (cnt_clr),
        .step_i (run),
        .pw_i   (hspw_q),
        .bp_i   (hsbp_q),
        .at_i   (hsat_q),
        .fp_i   (hsfp_q),
        .cnt_o  (h_cnt_w),
        .wrap_o (h_wrap),
        .sync_o (h_sync),
        .act_o  (h_act)
    );

    tcon_axis_cnt #(.CNT_BW(VCNT_BW), .PM_BW(VSPM_BW)) u_v_axis (
        .clk    (clk),
        .rstn   (rstn),
        .clr_i  (cnt_clr),
        .step_i (v_step),
        .pw_i   (vspw_q),
        .bp_i   (vsbp_q),
        .at_i   (vsat_q),
        .fp_i   (vsfp_q),
        .cnt_o  (v_cnt_w),
        .wrap_o (v_wrap),
        .sync_o (v_sync),
        .act_o  (v_act)
    );

    // Shadow registers; polarities reset active-high so outputs idle low
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hspw_q         <= '0;
            hsbp_q         <= '0;
            hsfp_q         <= '0;
            hsat_q         <= '0;
            vspw_q         <= '0;
            vsbp_q         <= '0;
            vsfp_q         <= '0;
            vsat_q         <= '0;
            line_irq_cfg_q <= '0;
            mode_q         <= '{hs_pol: 1'b1, vs_pol: 1'b1, de_pol: 1'b1, de_only: 1'b0};
        end else if (shd_load) begin
            hspw_q         <= reg_hspw;
            hsbp_q         <= reg_hsbp;
            hsfp_q         <= reg_hsfp;
            hsat_q         <= reg_hsat;
            vspw_q         <= reg_vspw;
            vsbp_q         <= reg_vsbp;
            vsfp_q         <= reg_vsfp;
            vsat_q         <= reg_vsat;
            line_irq_cfg_q <= reg_line_irq;
            mode_q         <= mode_in;
        end
    end

    // Update request: a pulse coinciding with a reload re-arms for the next frame end
    always_comb begin
        upd_pending_d = upd_pending_q;
        if (!run) begin
            upd_pending_d = 1'b0;
        end else begin
            if (reload) upd_pending_d = 1'b0;
            if (reg_upd) upd_pending_d = 1'b1;
        end
    end

    // Pending flag and completed-frame counter (cleared only by reset)
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            upd_pending_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            upd_pending_q <= upd_pending_d;
            if (frame_end) frame_cnt_q <= frame_cnt_q + FCNT_BW'(1);
        end
    end

    // Raw decodes before polarity
    always_comb begin
        hs_raw = h_sync && !mode_q.de_only;
        vs_raw = v_sync && !mode_q.de_only;
        de_raw = h_act && v_act;
    end

    // Output register stage: one cycle behind the counters, inactive when not running
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
            de_q          <= 1'b0;
            frame_start_q <= 1'b0;
            line_irq_q    <= 1'b0;
            upd_done_q    <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            if (run) begin
                hs_q          <= hs_raw ~^ mode_q.hs_pol;
                vs_q          <= vs_raw ~^ mode_q.vs_pol;
                de_q          <= de_raw ~^ mode_q.de_pol;
                frame_start_q <= (h_cnt_w == '0) && (v_cnt_w == '0);
                line_irq_q    <= (h_cnt_w == '0) && (v_cnt_w == line_irq_cfg_q);
            end else begin
                hs_q          <= inactive_lvl(mode_q.hs_pol);
                vs_q          <= inactive_lvl(mode_q.vs_pol);
                de_q          <= inactive_lvl(mode_q.de_pol);
                frame_start_q <= 1'b0;
                line_irq_q    <= 1'b0;
            end
            upd_done_q <= reload;
            cfg_err_q  <= (state_d == ST_ERR);
        end
    end

    assign h_cnt       = h_cnt_w;
    assign v_cnt       = v_cnt_w;
    assign hs_out      = hs_q;
    assign vs_out      = vs_q;
    assign de_out      = de_q;
    assign frame_start = frame_start_q;
    assign line_irq    = line_irq_q;
    assign frame_cnt   = frame_cnt_q;
    assign upd_done    = upd_done_q;
    assign cfg_err     = cfg_err_q;

endmodule
